// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with write-first read bypass and a pending-write scoreboard
// Read ports are registered; held operands follow writebacks to their captured address during a stall.
module regfile_scoreboard #(
  parameter int width_p = 32,
  parameter int els_p   = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_v_i,
  input  logic [$clog2(els_p)-1:0]   rs1_i,
  input  logic [$clog2(els_p)-1:0]   rs2_i,
  output logic [width_p-1:0]         rs1_data_o,
  output logic [width_p-1:0]         rs2_data_o,
  input  logic                       issue_v_i,
  input  logic [$clog2(els_p)-1:0]   issue_rd_i,
  input  logic [$clog2(els_p)-1:0]   rd_i,
  input  logic [width_p-1:0]         rd_data_i,
  input  logic                       rd_w_v_i,
  output logic                       hazard_o
);

  localparam int idx_w = $clog2(els_p);

  logic [width_p-1:0] regs [els_p];
  logic [els_p-1:0]   pending;
  logic [els_p-1:0]   pending_next;
  logic [idx_w-1:0]   rs1_addr;
  logic [idx_w-1:0]   rs2_addr;

  logic wb_nz;
  logic raw_1;
  logic raw_2;
  logic waw;
  logic issue_ok;

  assign wb_nz = rd_w_v_i && (rd_i != '0);

  // A same-cycle writeback to the register in question resolves the hazard through the bypass.
  assign raw_1 = (rs1_i != '0) && pending[rs1_i] && !(rd_w_v_i && (rd_i == rs1_i));
  assign raw_2 = (rs2_i != '0) && pending[rs2_i] && !(rd_w_v_i && (rd_i == rs2_i));
  assign waw   = issue_v_i && (issue_rd_i != '0) && pending[issue_rd_i]
                 && !(rd_w_v_i && (rd_i == issue_rd_i));

  assign hazard_o = raw_1 || raw_2 || waw;
  assign issue_ok = issue_v_i && !stall_v_i && !hazard_o && (issue_rd_i != '0);

  // Clear is applied before set so a simultaneous set of the same bit wins.
  always_comb begin
    pending_next = pending;
    if (wb_nz) pending_next[rd_i] = 1'b0;
    if (issue_ok) pending_next[issue_rd_i] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < els_p; i++) regs[i] <= '0;
      pending    <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      rs1_addr   <= '0;
      rs2_addr   <= '0;
    end else begin
      pending <= pending_next;
      if (wb_nz) regs[rd_i] <= rd_data_i;

      if (!stall_v_i) begin
        rs1_addr <= rs1_i;
        rs2_addr <= rs2_i;
        if (rs1_i == '0)                         rs1_data_o <= '0;
        else if (rd_w_v_i && (rd_i == rs1_i))    rs1_data_o <= rd_data_i;
        else                                     rs1_data_o <= regs[rs1_i];
        if (rs2_i == '0)                         rs2_data_o <= '0;
        else if (rd_w_v_i && (rd_i == rs2_i))    rs2_data_o <= rd_data_i;
        else                                     rs2_data_o <= regs[rs2_i];
      end else begin
        if (wb_nz && (rd_i == rs1_addr)) rs1_data_o <= rd_data_i;
        if (wb_nz && (rd_i == rs2_addr)) rs2_data_o <= rd_data_i;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed and randomized checks against a behavioural register/scoreboard model
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [4:0]  rs1, rs2, issue_rd, rd;
  logic [31:0] rs1_data, rs2_data, rd_data;
  logic        issue_v, rd_w_v, hazard;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model state
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  logic [31:0] m_rs1, m_rs2;
  int          m_a1, m_a2;
  logic        last_haz;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .stall_v_i  (stall),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .issue_v_i  (issue_v),
    .issue_rd_i (issue_rd),
    .rd_i       (rd),
    .rd_data_i  (rd_data),
    .rd_w_v_i   (rd_w_v),
    .hazard_o   (hazard)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_read(int a);
    if (a == 0) return 32'h0;
    if (rd_w_v && int'(rd) == a) return rd_data;
    return m_regs[a];
  endfunction

  function automatic bit model_hazard();
    bit r1, r2, w;
    r1 = (rs1 != 0) && m_pend[rs1] && !(rd_w_v && rd == rs1);
    r2 = (rs2 != 0) && m_pend[rs2] && !(rd_w_v && rd == rs2);
    w  = issue_v && (issue_rd != 0) && m_pend[issue_rd] && !(rd_w_v && rd == issue_rd);
    return r1 || r2 || w;
  endfunction

  // Drive one cycle of inputs, check hazard before the edge, advance the model, check read data after.
  task automatic step(input bit r, input bit s, input int a1, input int a2,
                      input bit iv, input int ird, input bit wv, input int wr,
                      input logic [31:0] wd);
    bit exp_haz;
    bool_wb: begin end
    rst = r; stall = s; rs1 = 5'(a1); rs2 = 5'(a2);
    issue_v = iv; issue_rd = 5'(ird); rd_w_v = wv; rd = 5'(wr); rd_data = wd;
    #1;
    exp_haz  = model_hazard();
    last_haz = hazard;
    check("hazard", {31'b0, hazard}, {31'b0, exp_haz});
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
      m_rs1 = 0; m_rs2 = 0; m_a1 = 0; m_a2 = 0;
    end else begin
      if (!s) begin
        m_rs1 = model_read(a1); m_a1 = a1;
        m_rs2 = model_read(a2); m_a2 = a2;
      end else begin
        if (wv && wr != 0 && wr == m_a1) m_rs1 = wd;
        if (wv && wr != 0 && wr == m_a2) m_rs2 = wd;
      end
      if (wv && wr != 0) m_pend[wr] = 0;
      if (iv && !s && !exp_haz && ird != 0) m_pend[ird] = 1;
      if (wv && wr != 0) m_regs[wr] = wd;
    end
    @(posedge clk);
    #1;
    check("rs1_data", rs1_data, m_rs1);
    check("rs2_data", rs2_data, m_rs2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
    m_rs1 = 0; m_rs2 = 0; m_a1 = 0; m_a2 = 0;
    rst = 1; stall = 1; rs1 = 0; rs2 = 0; issue_v = 1; issue_rd = 5'd3;
    rd_w_v = 1; rd = 5'd4; rd_data = 32'hA5A5A5A5;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rs1", rs1_data, 32'h0);
    check("reset_rs2", rs2_data, 32'h0);
    issue_v = 0; rd_w_v = 0; stall = 0; rst = 0;
    #1;
    check("reset_hazard", {31'b0, hazard}, 32'h0);

    // write then read
    step(0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    step(0, 0, 5, 0, 0, 0, 0, 0, 0);
    check("write_read", rs1_data, 32'hDEADBEEF);
    // bypass and x0
    step(0, 0, 0, 7, 0, 0, 1, 7, 32'h1234);
    check("bypass", rs2_data, 32'h1234);
    step(0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("x0_read", rs1_data, 32'h0);
    // stall tracking
    step(0, 0, 0, 0, 0, 0, 1, 3, 32'h11);
    step(0, 0, 3, 0, 0, 0, 0, 0, 0);
    check("stall_pre", rs1_data, 32'h11);
    step(0, 1, 0, 0, 0, 0, 1, 3, 32'h22);
    check("stall_track", rs1_data, 32'h22);
    step(0, 1, 0, 0, 0, 0, 1, 4, 32'h99);
    check("stall_other", rs1_data, 32'h22);
    // RAW
    step(0, 0, 0, 0, 1, 9, 0, 0, 0);
    step(0, 0, 9, 0, 0, 0, 0, 0, 0);
    check("raw_set", {31'b0, last_haz}, 32'h1);
    step(0, 0, 9, 0, 0, 0, 1, 9, 32'h55);
    check("raw_resolved", {31'b0, last_haz}, 32'h0);
    check("raw_bypass", rs1_data, 32'h55);
    // WAW and simultaneous set/clear
    step(0, 0, 0, 0, 1, 9, 0, 0, 0);
    step(0, 0, 0, 0, 1, 9, 0, 0, 0);
    check("waw", {31'b0, last_haz}, 32'h1);
    step(0, 0, 0, 0, 1, 9, 1, 9, 32'h66);
    check("set_clear_haz", {31'b0, last_haz}, 32'h0);
    step(0, 0, 9, 0, 0, 0, 0, 0, 0);
    check("set_wins", {31'b0, last_haz}, 32'h1);
    // reset mid-operation with pending {2,9}
    step(0, 0, 3, 5, 1, 2, 0, 0, 0);
    step(0, 0, 2, 9, 0, 0, 0, 0, 0);
    check("pend_2_9", {31'b0, last_haz}, 32'h1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_mid_rs1", rs1_data, 32'h0);
    step(0, 0, 2, 9, 0, 0, 0, 0, 0);
    check("rst_pend_clear", {31'b0, last_haz}, 32'h0);
    check("rst_x2", rs1_data, 32'h0);
    check("rst_x9", rs2_data, 32'h0);

    // randomized traffic over a narrow register range to force collisions
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
           $urandom_range(0, 2) != 0, int'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
